// File: rtl/traffic_light_controller.sv
// Highway / farm-lane intersection signal controller.
// Highway stays green until a lane vehicle is sensed, then the pair steps
// highway yellow -> lane green -> lane yellow -> back to highway green.
// The yellow intervals are ended by an external 3 s timer pulse.
module traffic_light_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor,
  input  logic       delay_3sec,
  output logic [1:0] highway,
  output logic [1:0] lane
);

  // Light encodings; 2'b11 is never driven.
  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  // state     | meaning
  // HGRE_LRED | highway green, lane red (rest state, waits for sensor)
  // HYEL_LRED | highway yellow, lane red (waits for timer pulse)
  // HRED_LGRE | highway red, lane green (held while vehicles remain)
  // HRED_LYEL | highway red, lane yellow (waits for timer pulse)
  localparam logic [1:0] HGRE_LRED = 2'b00;
  localparam logic [1:0] HYEL_LRED = 2'b01;
  localparam logic [1:0] HRED_LGRE = 2'b10;
  localparam logic [1:0] HRED_LYEL = 2'b11;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [1:0] state;
  logic       run_q;
  logic       run_d;

  // Visible name for the current state.
  assign state = state_q;

  // Release qualifier: the first edge after reset release only sets run_q,
  // so a release landing close to an edge can never half-update the FSM.
  // The FSM therefore first moves on the second edge after release.
  always_comb begin
    run_d = 1'b1;
  end

  // Release qualifier register, cleared asynchronously with the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= run_d;
    end
  end

  // Next-state logic: at most one step per edge; unknown states fall back
  // to highway green.
  always_comb begin
    state_d = state_q;
    if (run_q) begin
      case (state_q)
        HGRE_LRED: if (sensor)      state_d = HYEL_LRED;
        HYEL_LRED: if (delay_3sec)  state_d = HRED_LGRE;
        HRED_LGRE: if (!sensor)     state_d = HRED_LYEL;
        HRED_LYEL: if (delay_3sec)  state_d = HGRE_LRED;
        default:                    state_d = HGRE_LRED;
      endcase
    end
  end

  // State register with asynchronous abort to highway green.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HGRE_LRED;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode; an unknown state shows red both ways.
  always_comb begin
    highway = RED;
    lane    = RED;
    case (state_q)
      HGRE_LRED: begin highway = GREEN;  lane = RED;    end
      HYEL_LRED: begin highway = YELLOW; lane = RED;    end
      HRED_LGRE: begin highway = RED;    lane = GREEN;  end
      HRED_LYEL: begin highway = RED;    lane = YELLOW; end
      default:   begin highway = RED;    lane = RED;    end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
module tb_traffic_light_controller;

  logic       clk;
  logic       clk_en;
  logic       reset;
  logic       sensor;
  logic       delay_3sec;
  logic [1:0] highway;
  logic [1:0] lane;

  int total;
  int bad;

  typedef struct {
    logic       s;
    logic       d;
    logic [1:0] st;
    logic [1:0] hw;
    logic [1:0] ln;
  } vec_t;

  vec_t vecs [20];

  traffic_light_controller dut (
    .clk        (clk),
    .reset      (reset),
    .sensor     (sensor),
    .delay_3sec (delay_3sec),
    .highway    (highway),
    .lane       (lane)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [1:0] st, input logic [1:0] hw,
                           input logic [1:0] ln);
    check({name, ".state"},   dut.state, st);
    check({name, ".highway"}, highway,   hw);
    check({name, ".lane"},    lane,      ln);
  endtask

  task automatic step(input logic s, input logic d);
    sensor     = s;
    delay_3sec = d;
    @(posedge clk);
    #1;
  endtask

  // Never both directions non-red.
  always @(negedge clk) begin
    if (clk_en) begin
      total++;
      if (highway != 2'b10 && lane != 2'b10) begin
        bad++;
        $display("FAIL safety: highway=%b lane=%b at %0t", highway, lane, $time);
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    //         s     d     state  highway lane
    vecs[0]  = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b10};
    vecs[1]  = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b10};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b10};
    vecs[3]  = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00};
    vecs[4]  = '{1'b1, 1'b0, 2'b10, 2'b10, 2'b00};
    vecs[5]  = '{1'b1, 1'b1, 2'b10, 2'b10, 2'b00};
    vecs[6]  = '{1'b0, 1'b0, 2'b11, 2'b10, 2'b01};
    vecs[7]  = '{1'b1, 1'b0, 2'b11, 2'b10, 2'b01};
    vecs[8]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b10};
    vecs[9]  = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b10};
    vecs[10] = '{1'b0, 1'b0, 2'b00, 2'b00, 2'b10};
    vecs[11] = '{1'b1, 1'b1, 2'b01, 2'b01, 2'b10};
    vecs[12] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00};
    vecs[13] = '{1'b0, 1'b1, 2'b11, 2'b10, 2'b01};
    vecs[14] = '{1'b0, 1'b0, 2'b11, 2'b10, 2'b01};
    vecs[15] = '{1'b0, 1'b1, 2'b00, 2'b00, 2'b10};
    vecs[16] = '{1'b1, 1'b0, 2'b01, 2'b01, 2'b10};
    vecs[17] = '{1'b0, 1'b0, 2'b01, 2'b01, 2'b10};
    vecs[18] = '{1'b0, 1'b1, 2'b10, 2'b10, 2'b00};
    vecs[19] = '{1'b1, 1'b0, 2'b10, 2'b10, 2'b00};

    clk        = 1'b0;
    clk_en     = 1'b0;
    reset      = 1'b0;
    sensor     = 1'b0;
    delay_3sec = 1'b0;

    // Reset with the clock stopped.
    #17;
    check_all("reset_noclk", 2'b00, 2'b00, 2'b10);

    reset  = 1'b1;
    clk_en = 1'b1;
    step(1'b0, 1'b0);
    check_all("idle1", 2'b00, 2'b00, 2'b10);
    step(1'b0, 1'b0);
    check_all("idle2", 2'b00, 2'b00, 2'b10);

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].s, vecs[i].d);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].hw, vecs[i].ln);
    end

    // Asynchronous abort from lane green, no edge needed.
    #2;
    reset = 1'b0;
    #1;
    check_all("async_abort", 2'b00, 2'b00, 2'b10);
    step(1'b1, 1'b0);
    check_all("held_in_reset", 2'b00, 2'b00, 2'b10);

    // Release with sensor already high: first edge ignored, second moves.
    reset = 1'b1;
    step(1'b1, 1'b0);
    check_all("release_edge1", 2'b00, 2'b00, 2'b10);
    step(1'b1, 1'b0);
    check_all("release_edge2", 2'b01, 2'b01, 2'b10);
    step(1'b0, 1'b1);
    check_all("after_release", 2'b10, 2'b10, 2'b00);

    clk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
